// File: rtl/matrix_xform_seq_if.sv
// ---------------------------------------------------------------------------
// matrix_xform_seq_if
// Bundles the request, coefficient, vertex and strobe signals exchanged
// between matrix_xform_seq and its environment (requester + matrix_data).
//   master : the environment (drives start/coefs/vertices, observes strobes)
//   slave  : matrix_xform_seq itself
// Signals:
//   start, about_cen            request and centroid mode
//   coef_a..coef_d              signed Q(DW-FRAC).FRAC matrix [a b; c d]
//   tx, ty                      signed integer translation
//   max_point_cnt               vertex count-1 reported by matrix_data
//   x0,y0..x3,y3                current vertex registers of matrix_data
//   ld_obj_in, calc_from_cen    load / recentre strobes
//   ldback_reg, point_cnt       write mat_res_x/y into vertex point_cnt
//   writeback, writeback_cen    final writeback strobes
//   mat_res_x, mat_res_y        registered transform result
//   busy, done, cen_err         status
// ---------------------------------------------------------------------------
interface matrix_xform_seq_if #(
    parameter int DW = 16
);
    logic                 start;
    logic                 about_cen;
    logic signed [DW-1:0] coef_a;
    logic signed [DW-1:0] coef_b;
    logic signed [DW-1:0] coef_c;
    logic signed [DW-1:0] coef_d;
    logic signed [DW-1:0] tx;
    logic signed [DW-1:0] ty;
    logic [2:0]           max_point_cnt;
    logic signed [DW-1:0] x0;
    logic signed [DW-1:0] y0;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] y1;
    logic signed [DW-1:0] x2;
    logic signed [DW-1:0] y2;
    logic signed [DW-1:0] x3;
    logic signed [DW-1:0] y3;

    logic                 ld_obj_in;
    logic                 calc_from_cen;
    logic                 ldback_reg;
    logic [2:0]           point_cnt;
    logic                 writeback;
    logic                 writeback_cen;
    logic signed [DW-1:0] mat_res_x;
    logic signed [DW-1:0] mat_res_y;
    logic                 busy;
    logic                 done;
    logic                 cen_err;

    modport master (
        output start, about_cen, coef_a, coef_b, coef_c, coef_d, tx, ty,
               max_point_cnt, x0, y0, x1, y1, x2, y2, x3, y3,
        input  ld_obj_in, calc_from_cen, ldback_reg, point_cnt, writeback,
               writeback_cen, mat_res_x, mat_res_y, busy, done, cen_err
    );

    modport slave (
        input  start, about_cen, coef_a, coef_b, coef_c, coef_d, tx, ty,
               max_point_cnt, x0, y0, x1, y1, x2, y2, x3, y3,
        output ld_obj_in, calc_from_cen, ldback_reg, point_cnt, writeback,
               writeback_cen, mat_res_x, mat_res_y, busy, done, cen_err
    );
endinterface

// File: rtl/matrix_xform_seq.sv
// ---------------------------------------------------------------------------
// matrix_xform_seq
// Sequencer plus 2x2 fixed-point transform engine for the matrix_data
// register file. On an accepted start it loads an object, optionally
// recentres it on its centroid, computes res = M*p + t for every vertex,
// writes each result back via ldback_reg and finishes with a writeback
// (or writeback_cen) strobe followed by a one-cycle done pulse.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    matrix_xform_seq_if.slave (request, coefs, vertices, strobes)
// Parameters:
//   DW     vertex/result width (signed)
//   FRAC   fractional bits of the matrix coefficients
// ---------------------------------------------------------------------------
module matrix_xform_seq #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input logic               clk,
    input logic               rst_n,
    matrix_xform_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TYPE, S_CEN, S_MUL, S_LDB, S_WB, S_DONE
    } state_t;

    state_t               state_q, state_d;

    logic                 about_cen_q, about_cen_d;
    logic                 use_cen_q, use_cen_d;
    logic signed [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic signed [DW-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [2:0]           k_q, k_d;
    logic signed [DW-1:0] res_x_q, res_x_d, res_y_q, res_y_d;

    logic                 ld_q, ld_d;
    logic                 cen_q, cen_d;
    logic                 ldb_q, ldb_d;
    logic                 wb_q, wb_d;
    logic                 wbc_q, wbc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 last_vtx;
    logic                 type_is_tri;
    logic signed [DW-1:0] xk, yk;
    logic signed [2*DW:0] sum_x, sum_y;

    // Full-precision signed product; operands are sign-extended first so the
    // multiply is carried out at 2*DW bits.
    function automatic logic signed [2*DW-1:0] smul(
        input logic signed [DW-1:0] u,
        input logic signed [DW-1:0] v
    );
        logic signed [2*DW-1:0] ue, ve;
        ue = {{DW{u[DW-1]}}, u};
        ve = {{DW{v[DW-1]}}, v};
        return ue * ve;
    endfunction

    // Drop FRAC bits with floor (arithmetic shift), add the integer
    // translation and clamp to the signed DW range.
    function automatic logic signed [DW-1:0] shift_add_sat(
        input logic signed [2*DW:0]   sum,
        input logic signed [DW-1:0]   t
    );
        logic signed [2*DW+1:0] wide, te, r, max_v, min_v;
        wide  = {sum[2*DW], sum};
        wide  = wide >>> FRAC;
        te    = {{(DW+2){t[DW-1]}}, t};
        r     = wide + te;
        max_v = {{(DW+3){1'b0}}, {(DW-1){1'b1}}};
        min_v = {{(DW+3){1'b1}}, {(DW-1){1'b0}}};
        if (r > max_v) begin
            return max_v[DW-1:0];
        end else if (r < min_v) begin
            return min_v[DW-1:0];
        end
        return r[DW-1:0];
    endfunction

    assign accept      = (state_q == S_IDLE) && bus.start;
    assign last_vtx    = (k_q == bus.max_point_cnt);
    assign type_is_tri = (bus.max_point_cnt == 3'd2);

    // Vertex under transform
    always_comb begin
        xk = bus.x0;
        yk = bus.y0;
        case (k_q)
            3'd1: begin xk = bus.x1; yk = bus.y1; end
            3'd2: begin xk = bus.x2; yk = bus.y2; end
            3'd3: begin xk = bus.x3; yk = bus.y3; end
            default: begin xk = bus.x0; yk = bus.y0; end
        endcase
    end

    // Matrix-vector sums at 2*DW+1 bits so a+b of two extreme products
    // cannot wrap before the shift.
    always_comb begin
        logic signed [2*DW-1:0] pax, pby, pcx, pdy;
        pax   = smul(a_q, xk);
        pby   = smul(b_q, yk);
        pcx   = smul(c_q, xk);
        pdy   = smul(d_q, yk);
        sum_x = {pax[2*DW-1], pax} + {pby[2*DW-1], pby};
        sum_y = {pcx[2*DW-1], pcx} + {pdy[2*DW-1], pdy};
    end

    // State register and all other flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            about_cen_q <= 1'b0;
            use_cen_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            k_q         <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
            ld_q        <= 1'b0;
            cen_q       <= 1'b0;
            ldb_q       <= 1'b0;
            wb_q        <= 1'b0;
            wbc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            about_cen_q <= about_cen_d;
            use_cen_q   <= use_cen_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            k_q         <= k_d;
            res_x_q     <= res_x_d;
            res_y_q     <= res_y_d;
            ld_q        <= ld_d;
            cen_q       <= cen_d;
            ldb_q       <= ldb_d;
            wb_q        <= wb_d;
            wbc_q       <= wbc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. The centroid decision waits for TYPE because
    // max_point_cnt only reflects the new object one cycle after LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_LOAD;
            S_LOAD: state_d = S_TYPE;
            S_TYPE: state_d = (about_cen_q && !type_is_tri) ? S_CEN : S_MUL;
            S_CEN:  state_d = S_MUL;
            S_MUL:  state_d = S_LDB;
            S_LDB:  state_d = last_vtx ? S_WB : S_MUL;
            S_WB:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / latched request fields
    always_comb begin
        about_cen_d = about_cen_q;
        use_cen_d   = use_cen_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        k_d         = k_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        if (accept) begin
            about_cen_d = bus.about_cen;
            a_d         = bus.coef_a;
            b_d         = bus.coef_b;
            c_d         = bus.coef_c;
            d_d         = bus.coef_d;
            tx_d        = bus.tx;
            ty_d        = bus.ty;
            k_d         = 3'd0;
        end
        if (state_q == S_TYPE) begin
            use_cen_d = about_cen_q && !type_is_tri;
        end
        if (state_q == S_MUL) begin
            res_x_d = shift_add_sat(sum_x, tx_q);
            res_y_d = shift_add_sat(sum_y, ty_q);
        end
        if ((state_q == S_LDB) && !last_vtx) begin
            k_d = k_q + 3'd1;
        end
    end

    // Output decode from the next state so every strobe is a flop that is
    // valid during the cycle of the state it belongs to.
    always_comb begin
        ld_d   = (state_d == S_LOAD);
        cen_d  = (state_d == S_CEN);
        ldb_d  = (state_d == S_LDB);
        wb_d   = (state_d == S_WB) && !use_cen_d;
        wbc_d  = (state_d == S_WB) && use_cen_d;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign bus.ld_obj_in     = ld_q;
    assign bus.calc_from_cen = cen_q;
    assign bus.ldback_reg    = ldb_q;
    assign bus.writeback     = wb_q;
    assign bus.writeback_cen = wbc_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.point_cnt     = k_q;
    assign bus.mat_res_x     = res_x_q;
    assign bus.mat_res_y     = res_y_q;
    // The object type is only known during TYPE, so the error pulse is
    // decoded there directly from the live max_point_cnt.
    assign bus.cen_err       = (state_q == S_TYPE) && about_cen_q && type_is_tri;

endmodule

// File: tb/tb_matrix_xform_seq.sv
// ---------------------------------------------------------------------------
// tb_matrix_xform_seq
// Directed and randomized stimulus for matrix_xform_seq. A small stand-in
// for matrix_data holds the vertex registers; expected strobes, indices and
// results come from a cycle schedule and plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_matrix_xform_seq;
    localparam int DW   = 16;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matrix_xform_seq_if #(.DW(DW)) bus();
    matrix_xform_seq #(.DW(DW), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // matrix_data stand-in
    int                   obj_x [4];
    int                   obj_y [4];
    int                   obj_n;
    logic signed [DW-1:0] vx [4];
    logic signed [DW-1:0] vy [4];
    logic [2:0]           mpc;

    assign bus.x0 = vx[0];
    assign bus.y0 = vy[0];
    assign bus.x1 = vx[1];
    assign bus.y1 = vy[1];
    assign bus.x2 = vx[2];
    assign bus.y2 = vy[2];
    assign bus.x3 = vx[3];
    assign bus.y3 = vy[3];
    assign bus.max_point_cnt = mpc;

    function automatic longint floor_div(input longint s, input longint d);
        longint q;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) begin : mdata
        longint sx, sy;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            mpc <= 3'd0;
        end else begin
            if (bus.ld_obj_in) begin
                for (int i = 0; i < 4; i++) begin
                    vx[i] <= DW'(obj_x[i]);
                    vy[i] <= DW'(obj_y[i]);
                end
                mpc <= 3'(obj_n - 1);
            end
            if (bus.calc_from_cen) begin
                sx = 0;
                sy = 0;
                for (int i = 0; i <= int'(mpc); i++) begin
                    sx += longint'(vx[i]);
                    sy += longint'(vy[i]);
                end
                for (int i = 0; i <= int'(mpc); i++) begin
                    vx[i] <= DW'(longint'(vx[i]) - floor_div(sx, longint'(mpc) + 1));
                    vy[i] <= DW'(longint'(vy[i]) - floor_div(sy, longint'(mpc) + 1));
                end
            end
            if (bus.ldback_reg) begin
                vx[bus.point_cnt[1:0]] <= bus.mat_res_x;
                vy[bus.point_cnt[1:0]] <= bus.mat_res_y;
            end
        end
    end

    // Reference: floor((m0*x + m1*y) / 2^FRAC) + t, clamped to DW bits
    function automatic int ref_xf(input int m0, input int m1, input int x, input int y, input int t);
        longint s, r;
        s = longint'(m0) * x + longint'(m1) * y;
        r = floor_div(s, longint'(1) << FRAC) + t;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic int rnd16();
        logic [15:0] v;
        v = 16'($urandom);
        return int'($signed(v));
    endfunction

    function automatic int rnd_vtx();
        return int'($urandom_range(16000)) - 8000;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ld"},   longint'(bus.ld_obj_in), 0);
        chk({tag, ".cen"},  longint'(bus.calc_from_cen), 0);
        chk({tag, ".ldb"},  longint'(bus.ldback_reg), 0);
        chk({tag, ".wb"},   longint'(bus.writeback), 0);
        chk({tag, ".wbc"},  longint'(bus.writeback_cen), 0);
        chk({tag, ".busy"}, longint'(bus.busy), 0);
        chk({tag, ".done"}, longint'(bus.done), 0);
        chk({tag, ".err"},  longint'(bus.cen_err), 0);
        chk({tag, ".pc"},   longint'(bus.point_cnt), 0);
        chk({tag, ".rx"},   longint'(bus.mat_res_x), 0);
        chk({tag, ".ry"},   longint'(bus.mat_res_y), 0);
    endtask

    task automatic set_obj(input int i, input int x, input int y);
        obj_x[i] = x;
        obj_y[i] = y;
    endtask

    task automatic drive_req(input bit about, input int ca, input int cb, input int cc,
                             input int cd, input int tx, input int ty);
        bus.about_cen = about;
        bus.coef_a    = DW'(ca);
        bus.coef_b    = DW'(cb);
        bus.coef_c    = DW'(cc);
        bus.coef_d    = DW'(cd);
        bus.tx        = DW'(tx);
        bus.ty        = DW'(ty);
    endtask

    // One full transaction checked cycle by cycle against its schedule:
    // LOAD=1, TYPE=2, [CEN=3], then MUL/LDB pairs, WB, DONE.
    task automatic run_obj(input string tag, input int n, input bit about,
                           input int ca, input int cb, input int cc, input int cd,
                           input int tx, input int ty, input bit hold);
        bit     use_cen, terr, e_ldb;
        int     base, done_c, k, e_pc;
        int     ex [4];
        int     ey [4];
        longint sx, sy, cx, cy;
        obj_n   = n;
        use_cen = about && (n != 3);
        terr    = about && (n == 3);
        sx = 0; sy = 0; cx = 0; cy = 0;
        for (int i = 0; i < n; i++) begin
            sx += obj_x[i];
            sy += obj_y[i];
        end
        if (use_cen) begin
            cx = floor_div(sx, n);
            cy = floor_div(sy, n);
        end
        for (int i = 0; i < 4; i++) begin
            ex[i] = obj_x[i] - int'(cx);
            ey[i] = obj_y[i] - int'(cy);
        end
        base   = use_cen ? 4 : 3;
        done_c = base + 2 * n + 1;

        @(negedge clk);
        drive_req(about, ca, cb, cc, cd, tx, ty);
        bus.start = 1'b1;
        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk);
            #1;
            k     = (c >= base) ? (c - base) / 2 : 0;
            e_ldb = (c >= base) && (c < base + 2 * n) && ((c - base) % 2 == 1);
            e_pc  = (c < base) ? 0 : ((k > n - 1) ? n - 1 : k);
            chk({tag, ".ld"},   longint'(bus.ld_obj_in),     longint'(c == 1));
            chk({tag, ".err"},  longint'(bus.cen_err),       longint'(terr && c == 2));
            chk({tag, ".cen"},  longint'(bus.calc_from_cen), longint'(use_cen && c == 3));
            chk({tag, ".ldb"},  longint'(bus.ldback_reg),    longint'(e_ldb));
            chk({tag, ".wb"},   longint'(bus.writeback),     longint'(!use_cen && c == done_c - 1));
            chk({tag, ".wbc"},  longint'(bus.writeback_cen), longint'(use_cen && c == done_c - 1));
            chk({tag, ".done"}, longint'(bus.done),          longint'(c == done_c));
            chk({tag, ".busy"}, longint'(bus.busy),          longint'(c <= done_c));
            chk({tag, ".pc"},   longint'(bus.point_cnt),     longint'(e_pc));
            if (e_ldb) begin
                chk({tag, ".rx"}, longint'(bus.mat_res_x), ref_xf(ca, cb, ex[k], ey[k], tx));
                chk({tag, ".ry"}, longint'(bus.mat_res_y), ref_xf(cc, cd, ex[k], ey[k], ty));
            end
            if (c == 1) begin
                // Request fields must already be latched
                drive_req(!about, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
                if (!hold) bus.start = 1'b0;
            end
            if (c == done_c) bus.start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            chk({tag, ".objx"}, longint'(vx[i]), ref_xf(ca, cb, ex[i], ey[i], tx));
            chk({tag, ".objy"}, longint'(vy[i]), ref_xf(cc, cd, ex[i], ey[i], ty));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drive_req(1'b0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) set_obj(i, 0, 0);
        obj_n = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;

        // Identity on a line
        set_obj(0, 10, 20);
        set_obj(1, -5, 7);
        run_obj("ident", 2, 1'b0, 256, 0, 0, 256, 0, 0, 1'b0);
        chk("ident.v0x", longint'(vx[0]), 10);
        chk("ident.v1y", longint'(vy[1]), 7);

        // Rotate 90 degrees plus shift
        set_obj(0, 3, 4);
        run_obj("rot", 1, 1'b0, 0, -256, 256, 0, 1, 0, 1'b0);
        chk("rot.x", longint'(vx[0]), -3);
        chk("rot.y", longint'(vy[0]), 3);

        // Floor toward -inf
        set_obj(0, -3, 0);
        run_obj("floor", 1, 1'b0, 128, 0, 0, 0, 0, 0, 1'b0);
        chk("floor.x", longint'(vx[0]), -2);

        // Positive and negative saturation
        set_obj(0, 32767, 0);
        set_obj(1, -32768, 0);
        run_obj("sat", 2, 1'b0, 32767, 0, 0, 0, 0, 0, 1'b0);
        chk("sat.pos", longint'(vx[0]), 32767);
        chk("sat.neg", longint'(vx[1]), -32768);

        // Triangle with centroid request: error pulse, plain transform
        for (int i = 0; i < 3; i++) set_obj(i, rnd_vtx(), rnd_vtx());
        run_obj("tri", 3, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);

        // Quad about centroid with start held high throughout
        for (int i = 0; i < 4; i++) set_obj(i, rnd_vtx(), rnd_vtx());
        run_obj("quadcen", 4, 1'b1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);

        // Randomized objects
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) set_obj(i, rnd_vtx(), rnd_vtx());
            run_obj("rand", int'($urandom_range(4, 1)), 1'(($urandom) & 1),
                    rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'(($urandom) & 1));
        end

        // Reset during LDB of vertex 1 of a plain quad
        for (int i = 0; i < 4; i++) set_obj(i, rnd_vtx(), rnd_vtx());
        obj_n = 4;
        @(negedge clk);
        drive_req(1'b0, 256, 0, 0, 256, 0, 0);
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("abort.ldb", longint'(bus.ldback_reg), 1);
        chk("abort.pc", longint'(bus.point_cnt), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("abort");
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk("abort.nodone", longint'(bus.done), 0);
            chk("abort.nobusy", longint'(bus.busy), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
